// File: rtl/vga_rx_monitor.sv
// Receive-side VGA monitor: rebuilds pixel coordinates from HS/VS, checks sync timing,
// tracks lock and finds the top-left non-black active pixel of every frame.
module vga_rx_monitor #(
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_TOTAL     = 525,
  parameter logic        SYNC_ACT    = 1'b0,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_hs,
  input  logic       I_vs,
  input  logic [3:0] I_red,
  input  logic [3:0] I_green,
  input  logic [3:0] I_blue,
  output logic       O_locked,
  output logic       O_h_err,
  output logic       O_v_err,
  input  logic       O_err_clr,
  output logic [9:0] O_box_x,
  output logic [9:0] O_box_y,
  output logic       O_box_valid,
  output logic       O_frame_done
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_CHECK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam logic [9:0]  H_ACT_LO = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  H_ACT_HI = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_ACT_LO = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_ACT_HI = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [10:0] H_TOT    = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT    = 11'(V_TOTAL);
  localparam logic [9:0]  HS_LEN   = 10'(H_SYNC);
  localparam logic [9:0]  VS_LEN   = 10'(V_SYNC);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX  = 10'h3FF;

  logic        r_s_hs, r_s_vs, r_prev_hs, r_prev_vs;
  logic [11:0] r_s_rgb;
  logic [9:0]  r_hcnt, r_vcnt, r_hs_width, r_vs_width;
  logic [1:0]  r_state;
  logic [3:0]  r_good;
  logic        r_locked, r_h_err, r_v_err;
  logic [9:0]  r_min_x, r_min_y, r_box_x, r_box_y;
  logic        r_found, r_seen_vs, r_box_valid, r_frame_done;

  logic        w_hs_act, w_vs_act, w_hs_edge, w_vs_edge, w_hs_fall, w_vs_fall;
  logic [9:0]  w_hpos, w_vpos, w_x, w_y;
  logic        w_active, w_lit, w_checking, w_h_bad, w_v_bad;
  logic [1:0]  w_state_d;
  logic [3:0]  w_good_d;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_s_hs    <= ~SYNC_ACT;
      r_s_vs    <= ~SYNC_ACT;
      r_prev_hs <= ~SYNC_ACT;
      r_prev_vs <= ~SYNC_ACT;
      r_s_rgb   <= '0;
    end else begin
      r_s_hs    <= I_hs;
      r_s_vs    <= I_vs;
      r_prev_hs <= r_s_hs;
      r_prev_vs <= r_s_vs;
      r_s_rgb   <= {I_red, I_green, I_blue};
    end
  end

  // Position of the sample currently in the input stage; r_hcnt/r_vcnt hold the previous one.
  always_comb begin
    w_hs_act  = (r_s_hs == SYNC_ACT);
    w_vs_act  = (r_s_vs == SYNC_ACT);
    w_hs_edge = w_hs_act && (r_prev_hs != SYNC_ACT);
    w_vs_edge = w_vs_act && (r_prev_vs != SYNC_ACT);
    w_hs_fall = !w_hs_act && (r_prev_hs == SYNC_ACT);
    w_vs_fall = !w_vs_act && (r_prev_vs == SYNC_ACT);
    w_hpos    = w_hs_edge ? '0 : ((r_hcnt == CNT_MAX) ? CNT_MAX : r_hcnt + 10'd1);
    if (w_vs_edge) w_vpos = '0;
    else if (w_hs_edge && r_vcnt != CNT_MAX) w_vpos = r_vcnt + 10'd1;
    else w_vpos = r_vcnt;
    w_active   = (w_hpos >= H_ACT_LO) && (w_hpos < H_ACT_HI) &&
                 (w_vpos >= V_ACT_LO) && (w_vpos < V_ACT_HI);
    w_x        = w_hpos - H_ACT_LO;
    w_y        = w_vpos - V_ACT_LO;
    w_lit      = w_active && (r_s_rgb != 12'd0);
    w_checking = (r_state != S_SEARCH);
    w_h_bad    = w_checking && ((w_hs_edge && ({1'b0, r_hcnt} + 11'd1 != H_TOT)) ||
                                (w_hs_fall && r_hs_width != HS_LEN));
    w_v_bad    = w_checking && ((w_vs_edge && ({1'b0, r_vcnt} + 11'd1 != V_TOT)) ||
                                (w_vs_fall && r_vs_width != VS_LEN));
  end

  always_comb begin
    w_state_d = r_state;
    w_good_d  = r_good;
    case (r_state)
      S_SEARCH: begin
        if (w_vs_edge) begin
          w_state_d = S_CHECK;
          w_good_d  = '0;
        end
      end
      S_CHECK: begin
        if (w_h_bad || w_v_bad) begin
          w_state_d = S_SEARCH;
        end else if (w_vs_edge) begin
          w_good_d = r_good + 4'd1;
          if (w_good_d == LOCK_N) w_state_d = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (w_h_bad || w_v_bad) w_state_d = S_SEARCH;
      end
      default: w_state_d = S_SEARCH;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_hs_width <= '0;
      r_vs_width <= '0;
      r_state    <= S_SEARCH;
      r_good     <= '0;
      r_locked   <= 1'b0;
      r_h_err    <= 1'b0;
      r_v_err    <= 1'b0;
    end else begin
      r_hcnt  <= w_hpos;
      r_vcnt  <= w_vpos;
      r_state <= w_state_d;
      r_good  <= w_good_d;
      r_locked <= (w_state_d == S_LOCKED);
      // A fresh error overrides a coincident clear.
      r_h_err <= w_h_bad || (r_h_err && !O_err_clr);
      r_v_err <= w_v_bad || (r_v_err && !O_err_clr);
      if (w_hs_edge) r_hs_width <= 10'd1;
      else if (w_hs_act && r_hs_width != CNT_MAX) r_hs_width <= r_hs_width + 10'd1;
      if (w_vs_edge) r_vs_width <= 10'd1;
      else if (w_vs_act && w_hs_edge && r_vs_width != CNT_MAX) r_vs_width <= r_vs_width + 10'd1;
    end
  end

  // The sample taken on the VS edge already belongs to the new frame.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_min_x      <= CNT_MAX;
      r_min_y      <= CNT_MAX;
      r_found      <= 1'b0;
      r_seen_vs    <= 1'b0;
      r_box_x      <= '0;
      r_box_y      <= '0;
      r_box_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (w_vs_edge) begin
      if (r_seen_vs) begin
        if (r_found) begin
          r_box_x <= r_min_x;
          r_box_y <= r_min_y;
        end
        r_box_valid <= r_found;
      end
      r_frame_done <= r_seen_vs;
      r_seen_vs    <= 1'b1;
      r_found      <= w_lit;
      r_min_x      <= w_lit ? w_x : CNT_MAX;
      r_min_y      <= w_lit ? w_y : CNT_MAX;
    end else begin
      r_frame_done <= 1'b0;
      if (w_lit) begin
        r_found <= 1'b1;
        if (w_x < r_min_x) r_min_x <= w_x;
        if (w_y < r_min_y) r_min_y <= w_y;
      end
    end
  end

  assign O_locked     = r_locked;
  assign O_h_err      = r_h_err;
  assign O_v_err      = r_v_err;
  assign O_box_x      = r_box_x;
  assign O_box_y      = r_box_y;
  assign O_box_valid  = r_box_valid;
  assign O_frame_done = r_frame_done;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor: drives a reduced-size VGA stream and scores per-frame box reports
// against a queue filled from the stimulus.
module tb_vga_rx_monitor;

  localparam int HS = 4, HB = 4, HA = 16, HT = 28;
  localparam int VS = 2, VB = 3, VA = 12, VT = 20;
  localparam int XLO = HS + HB, YLO = VS + VB;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       hs = 1'b1, vs = 1'b1, err_clr = 1'b0;
  logic [3:0] red = '0, green = '0, blue = '0;
  logic       locked, h_err, v_err, box_valid, frame_done;
  logic [9:0] box_x, box_y;

  vga_rx_monitor #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .SYNC_ACT(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_hs(hs), .I_vs(vs),
    .I_red(red), .I_green(green), .I_blue(blue),
    .O_locked(locked), .O_h_err(h_err), .O_v_err(v_err), .O_err_clr(err_clr),
    .O_box_x(box_x), .O_box_y(box_y), .O_box_valid(box_valid), .O_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0, n_fail = 0;
  bit   m_found = 0, m_seen = 0, m_prev_vs = 0;
  int   m_min_x = 1023, m_min_y = 1023, m_held_x = 0, m_held_y = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_pixel(input logic h_v, input logic v_v, input logic [11:0] rgb);
    hs = h_v;
    vs = v_v;
    {red, green, blue} = rgb;
    @(posedge clk);
    #1;
  endtask

  // Reference model: frame boundary on VS assertion, pushes the finished frame's report.
  task automatic model_pixel(input int h, input int v, input bit v_act, input logic [11:0] rgb);
    exp_t e;
    if (v_act && !m_prev_vs) begin
      if (m_seen) begin
        if (m_found) begin
          m_held_x = m_min_x;
          m_held_y = m_min_y;
        end
        e.valid = m_found;
        e.x     = 10'(m_held_x);
        e.y     = 10'(m_held_y);
        sb_q.push_back(e);
      end
      m_seen  = 1;
      m_found = 0;
      m_min_x = 1023;
      m_min_y = 1023;
    end
    m_prev_vs = v_act;
    if (rgb != 12'd0 && h >= XLO && h < XLO + HA && v >= YLO && v < YLO + VA) begin
      m_found = 1;
      if (h - XLO < m_min_x) m_min_x = h - XLO;
      if (v - YLO < m_min_y) m_min_y = v - YLO;
    end
  endtask

  task automatic drive_frame(input int first, input int last, input int vs_lines,
                             input int short_line, input int bx, input int by, input int bw,
                             input int bh, input bit sync_dot, input int probe_line,
                             input bit exp_h, input bit exp_v, input int clr_line);
    for (int v = first; v <= last; v++) begin
      int len;
      len = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        logic [11:0] rgb;
        bit          va;
        rgb = '0;
        if (bw > 0 && h - XLO >= bx && h - XLO < bx + bw && v - YLO >= by && v - YLO < by + bh)
          rgb = (bw == 1) ? 12'h0F0 : 12'hFFF;
        if (sync_dot && v == 10 && h == 2) rgb = 12'h00F;
        if (v == probe_line && h == 0) check_val("locked_before_err", locked, 1);
        if (v == probe_line && h == 2) begin
          check_val("h_err_after_err", h_err, exp_h);
          check_val("v_err_after_err", v_err, exp_v);
          check_val("unlock_after_err", locked, 0);
        end
        if (v == clr_line && h == 20) begin
          check_val("h_err_pre_clr", h_err, 1);
          check_val("v_err_pre_clr", v_err, 1);
          err_clr = 1'b1;
        end
        if (v == clr_line && h == 21) begin
          err_clr = 1'b0;
          check_val("h_err_post_clr", h_err, 0);
          check_val("v_err_post_clr", v_err, 0);
        end
        va = (v < vs_lines);
        model_pixel(h, v, va, rgb);
        drive_pixel((h < HS) ? 1'b0 : 1'b1, va ? 1'b0 : 1'b1, rgb);
      end
    end
  endtask

  task automatic frame_plain();
    drive_frame(0, VT - 1, VS, -1, 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b0, -1);
  endtask

  task automatic frame_box(input int bx, input int by, input int bw, input int bh);
    drive_frame(0, VT - 1, VS, -1, bx, by, bw, bh, 1'b0, -1, 1'b0, 1'b0, -1);
  endtask

  task automatic check_reset_outputs(input string phase);
    check_val({phase, "_locked"}, locked, 0);
    check_val({phase, "_h_err"}, h_err, 0);
    check_val({phase, "_v_err"}, v_err, 0);
    check_val({phase, "_box_x"}, box_x, 0);
    check_val({phase, "_box_y"}, box_y, 0);
    check_val({phase, "_box_valid"}, box_valid, 0);
    check_val({phase, "_frame_done"}, frame_done, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && frame_done) begin
      check_val("frame_done_expected", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check_val("box_valid", box_valid, e.valid);
        check_val("box_x", box_x, e.x);
        check_val("box_y", box_y, e.y);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Clean black frames: lock on the third VS edge.
    for (int f = 1; f <= 3; f++) begin
      frame_plain();
      check_val("lock_ramp", locked, 32'(f == 3));
    end
    check_val("clean_h_err", h_err, 0);
    check_val("clean_v_err", v_err, 0);
    check_val("black_box_valid", box_valid, 0);

    // Box frame, then black frames that must hold the coordinates.
    frame_box(5, 3, 4, 4);
    frame_plain();
    frame_plain();

    // One short line, then relock after two clean frames with h_err still sticky.
    drive_frame(0, VT - 1, VS, 10, 0, 0, 0, 0, 1'b0, 11, 1'b1, 1'b0, -1);
    for (int f = 8; f <= 10; f++) begin
      frame_plain();
      check_val("relock", locked, 32'(f == 10));
    end
    check_val("h_err_sticky", h_err, 1);

    // VS held for three lines, then clear both errors.
    drive_frame(0, VT - 1, 3, -1, 0, 0, 0, 0, 1'b0, 3, 1'b1, 1'b1, -1);
    drive_frame(0, VT - 1, VS, -1, 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b0, 5);

    // Non-black pixel only in the sync area.
    drive_frame(0, VT - 1, VS, -1, 0, 0, 0, 0, 1'b1, -1, 1'b0, 1'b0, -1);
    frame_plain();

    // Other positions including the first and last active pixels.
    frame_box(10, 7, 3, 3);
    frame_box(0, 0, 1, 1);
    frame_box(HA - 1, VA - 1, 1, 1);

    // Reset mid-frame.
    drive_frame(0, 9, VS, -1, 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b0, -1);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("async_reset");
    m_seen    = 0;
    m_found   = 0;
    m_prev_vs = 0;
    m_held_x  = 0;
    m_held_y  = 0;
    hs = 1'b1;
    vs = 1'b1;
    {red, green, blue} = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_frame(10, VT - 1, VS, -1, 0, 0, 0, 0, 1'b0, -1, 1'b0, 1'b0, -1);
    for (int f = 19; f <= 21; f++) begin
      frame_plain();
      check_val("post_reset_lock", locked, 32'(f == 21));
    end
    check_val("post_reset_h_err", h_err, 0);
    check_val("post_reset_v_err", v_err, 0);

    repeat (5) drive_pixel(1'b1, 1'b1, 12'd0);
    check_val("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
